// File: rtl/ntt_fifo_pkg.sv
// rtl/ntt_fifo_pkg.sv - shared helpers and encodings for the NTT tap delay line
package ntt_fifo_pkg;

   localparam int BYPASS_DEPTH = 0;

   function automatic int depth_w(input int max_depth);
      return $clog2(max_depth + 1);
   endfunction

   // Bit offset of slot `idx` in a flat vector of `width`-bit words.
   function automatic int lane_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/ntt_tap_mux.sv
// rtl/ntt_tap_mux.sv - MAX_DEPTH:1 read mux selecting entry sel_depth-1 of one lane
module ntt_tap_mux
   import ntt_fifo_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int MAX_DEPTH = 64,
   parameter int DEPTH_W   = 7
) (
   input  logic [MAX_DEPTH*WIDTH-1:0] entries,
   input  logic [DEPTH_W-1:0]         sel_depth,
   output logic [WIDTH-1:0]           tap
);

   // Depth 0 falls back to entry 0; the top replaces it with the bypass path.
   always_comb begin
      tap = entries[0 +: WIDTH];
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (sel_depth == DEPTH_W'(i + 1)) begin
            tap = entries[lane_lsb(i, WIDTH) +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/ntt_tap_delay_line.sv
// rtl/ntt_tap_delay_line.sv - multi-lane shift delay line with runtime tap depth and valid tracking
module ntt_tap_delay_line
   import ntt_fifo_pkg::*;
#(
   parameter int  LANES     = 2,
   parameter int  WIDTH     = 64,
   parameter int  MAX_DEPTH = 64,
   localparam int DEPTH_W   = depth_w(MAX_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       rst_val,
   input  logic                   cfg_load,
   input  logic [DEPTH_W-1:0]     cfg_depth,
   input  logic                   flush,
   input  logic                   shift,
   input  logic                   in_valid,
   input  logic [LANES*WIDTH-1:0] data_in,
   output logic [LANES*WIDTH-1:0] data_out,
   output logic                   out_valid,
   output logic [LANES*WIDTH-1:0] last_data_in,
   output logic                   primed,
   output logic [DEPTH_W-1:0]     active_depth,
   output logic                   cfg_err
);

   localparam logic [DEPTH_W-1:0] MAX_D  = DEPTH_W'(MAX_DEPTH);
   localparam logic [DEPTH_W-1:0] BYPASS = DEPTH_W'(BYPASS_DEPTH);

   logic [MAX_DEPTH*WIDTH-1:0] lane_sr [LANES];
   logic [MAX_DEPTH-1:0]       valid_sr;
   logic [DEPTH_W-1:0]         prime_cnt;
   logic                       cfg_over;
   logic                       valid_tap;
   logic                       bypass;

   assign cfg_over = (cfg_depth > MAX_D);
   assign bypass   = (active_depth == BYPASS);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
               lane_sr[l][lane_lsb(i, WIDTH) +: WIDTH] <= rst_val;
            end
         end
         valid_sr     <= '0;
         prime_cnt    <= '0;
         active_depth <= MAX_D;
         cfg_err      <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         if (cfg_load) begin
            active_depth <= cfg_over ? MAX_D : cfg_depth;
            cfg_err      <= cfg_over;
            valid_sr     <= '0;
            prime_cnt    <= '0;
         end else if (flush) begin
            valid_sr  <= '0;
            prime_cnt <= '0;
         end else if (shift) begin
            for (int l = 0; l < LANES; l++) begin
               for (int i = MAX_DEPTH - 1; i > 0; i--) begin
                  lane_sr[l][lane_lsb(i, WIDTH) +: WIDTH] <= lane_sr[l][lane_lsb(i - 1, WIDTH) +: WIDTH];
               end
               lane_sr[l][0 +: WIDTH] <= data_in[lane_lsb(l, WIDTH) +: WIDTH];
            end
            for (int i = MAX_DEPTH - 1; i > 0; i--) begin
               valid_sr[i] <= valid_sr[i - 1];
            end
            valid_sr[0] <= in_valid;
            if (prime_cnt < active_depth) begin
               prime_cnt <= prime_cnt + DEPTH_W'(1);
            end
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [WIDTH-1:0] tap;

      ntt_tap_mux #(
         .WIDTH     (WIDTH),
         .MAX_DEPTH (MAX_DEPTH),
         .DEPTH_W   (DEPTH_W)
      ) u_mux (
         .entries   (lane_sr[l]),
         .sel_depth (active_depth),
         .tap       (tap)
      );

      assign data_out[lane_lsb(l, WIDTH) +: WIDTH]     = bypass ? data_in[lane_lsb(l, WIDTH) +: WIDTH] : tap;
      assign last_data_in[lane_lsb(l, WIDTH) +: WIDTH] = lane_sr[l][0 +: WIDTH];
   end

   ntt_tap_mux #(
      .WIDTH     (1),
      .MAX_DEPTH (MAX_DEPTH),
      .DEPTH_W   (DEPTH_W)
   ) u_valid_mux (
      .entries   (valid_sr),
      .sel_depth (active_depth),
      .tap       (valid_tap)
   );

   assign out_valid = bypass ? in_valid : valid_tap;
   assign primed    = (prime_cnt == active_depth);

endmodule

// File: tb/tb_ntt_tap_delay_line.sv
// tb/tb_ntt_tap_delay_line.sv - directed self-checking bench for ntt_tap_delay_line
module tb_ntt_tap_delay_line;

   localparam int LANES     = 2;
   localparam int WIDTH     = 8;
   localparam int MAX_DEPTH = 4;
   localparam int DEPTH_W   = 3;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [WIDTH-1:0]       rst_val;
   logic                   cfg_load;
   logic [DEPTH_W-1:0]     cfg_depth;
   logic                   flush;
   logic                   shift;
   logic                   in_valid;
   logic [LANES*WIDTH-1:0] data_in;
   logic [LANES*WIDTH-1:0] data_out;
   logic                   out_valid;
   logic [LANES*WIDTH-1:0] last_data_in;
   logic                   primed;
   logic [DEPTH_W-1:0]     active_depth;
   logic                   cfg_err;

   int errors = 0;
   int checks = 0;

   ntt_tap_delay_line #(
      .LANES     (LANES),
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rst_val      (rst_val),
      .cfg_load     (cfg_load),
      .cfg_depth    (cfg_depth),
      .flush        (flush),
      .shift        (shift),
      .in_valid     (in_valid),
      .data_in      (data_in),
      .data_out     (data_out),
      .out_valid    (out_valid),
      .last_data_in (last_data_in),
      .primed       (primed),
      .active_depth (active_depth),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_depth(input logic [DEPTH_W-1:0] d);
      cfg_load  = 1'b1;
      cfg_depth = d;
      step();
      cfg_load  = 1'b0;
   endtask

   logic [1:0] vpat [4];
   logic [1:0] vexp [4];

   initial begin
      rst = 1'b1; rst_val = 8'hAB; cfg_load = 1'b0; cfg_depth = '0;
      flush = 1'b0; shift = 1'b0; in_valid = 1'b0; data_in = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_data_out", 64'(data_out), 64'hABAB);
      check("rst_last_in", 64'(last_data_in), 64'hABAB);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_primed", 64'(primed), 64'd0);
      check("rst_depth", 64'(active_depth), 64'd4);
      check("rst_cfg_err", 64'(cfg_err), 64'd0);

      // depth 3: word k reaches the tap after shift k+2
      load_depth(3'd3);
      check("d3_depth", 64'(active_depth), 64'd3);
      check("d3_primed0", 64'(primed), 64'd0);
      for (int k = 1; k <= 6; k++) begin
         data_in  = {8'(k + 16), 8'(k)};
         in_valid = 1'b1;
         shift    = 1'b1;
         step();
         check($sformatf("d3_primed_%0d", k), 64'(primed), 64'(k >= 3));
         check($sformatf("d3_valid_%0d", k), 64'(out_valid), 64'(k >= 3));
         if (k >= 3)
            check($sformatf("d3_data_%0d", k), 64'(data_out), {48'd0, 8'(k - 2 + 16), 8'(k - 2)});
         else
            check($sformatf("d3_data_%0d", k), 64'(data_out), 64'hABAB);
      end
      shift = 1'b0;

      // bypass: combinational path, no clock edge needed
      load_depth(3'd0);
      data_in  = 16'h6555;
      in_valid = 1'b1;
      #1;
      check("byp_data", 64'(data_out), 64'h6555);
      check("byp_valid", 64'(out_valid), 64'd1);
      check("byp_primed", 64'(primed), 64'd1);
      in_valid = 1'b0;
      #1;
      check("byp_valid_low", 64'(out_valid), 64'd0);

      // oversized request clamps and pulses cfg_err once
      load_depth(3'd7);
      check("clamp_depth", 64'(active_depth), 64'd4);
      check("clamp_err_hi", 64'(cfg_err), 64'd1);
      step();
      check("clamp_err_lo", 64'(cfg_err), 64'd0);
      load_depth(3'd4);
      check("max_depth_ok", 64'(active_depth), 64'd4);
      check("max_err_lo", 64'(cfg_err), 64'd0);

      // flush wins over a simultaneous shift
      load_depth(3'd3);
      in_valid = 1'b1;
      shift    = 1'b1;
      data_in  = 16'h4131; step();
      data_in  = 16'h4232; step();
      flush    = 1'b1;
      data_in  = 16'h4333; step();
      flush    = 1'b0;
      check("fl_hold", 64'(last_data_in), 64'h4232);
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_primed", 64'(primed), 64'd0);
      data_in = 16'h4434; step();
      data_in = 16'h4535; step();
      check("fl_primed2", 64'(primed), 64'd0);
      data_in = 16'h4636; step();
      check("fl_primed3", 64'(primed), 64'd1);
      check("fl_valid3", 64'(out_valid), 64'd1);
      check("fl_data3", 64'(data_out), 64'h4434);
      shift = 1'b0;

      // valid pattern at depth 2
      load_depth(3'd2);
      vpat[0] = 2'd1; vpat[1] = 2'd0; vpat[2] = 2'd1; vpat[3] = 2'd0;
      vexp[0] = 2'd0; vexp[1] = 2'd1; vexp[2] = 2'd0; vexp[3] = 2'd1;
      shift = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = vpat[k][0];
         data_in  = {8'(k + 32), 8'(k + 16)};
         step();
         check($sformatf("vp_valid_%0d", k + 1), 64'(out_valid), 64'(vexp[k][0]));
      end
      check("vp_data", 64'(data_out), 64'h2212);

      // reset mid-stream overrides simultaneous cfg_load and shift
      rst      = 1'b1;
      rst_val  = 8'h5A;
      cfg_load = 1'b1;
      cfg_depth = 3'd1;
      in_valid = 1'b1;
      step();
      rst = 1'b0; cfg_load = 1'b0; shift = 1'b0;
      check("mrst_valid", 64'(out_valid), 64'd0);
      check("mrst_primed", 64'(primed), 64'd0);
      check("mrst_depth", 64'(active_depth), 64'd4);
      check("mrst_data", 64'(data_out), 64'h5A5A);
      check("mrst_last", 64'(last_data_in), 64'h5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
